// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state encoding, default header byte and
// baud-derived timing constants for the frame assembler.
package uart_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } frame_state_t;

    localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;
    localparam int         CLK_HZ           = 50_000_000;
    localparam int         BITS_PER_BYTE    = 10;
    localparam int         TIMEOUT_BYTES    = 2;

    function automatic int baud_rate(input logic [2:0] baud_set);
        case (baud_set)
            3'd0:    return 9600;
            3'd1:    return 19200;
            3'd2:    return 38400;
            3'd3:    return 57600;
            default: return 115200;
        endcase
    endfunction

    // Inter-byte gap allowed inside a frame: TIMEOUT_BYTES full byte times.
    function automatic int timeout_clks(input logic [2:0] baud_set);
        return (TIMEOUT_BYTES * BITS_PER_BYTE * CLK_HZ) / baud_rate(baud_set);
    endfunction

    localparam int DEFAULT_TIMEOUT_CLKS = timeout_clks(3'd0);

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte watchdog: counts enabled clocks since the last clear and flags
// the terminal count so the frame assembler can abandon a stalled frame.
module uart_frame_timer #(
    parameter int TIMEOUT_CLKS = 104166
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] count;

    // Saturates at the terminal value; the owner clears it once it reacts.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// Multi-byte UART frame assembler: header hunt, payload collection, optional
// XOR checksum, packing and a valid/ready output holding register.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int         NUM_BYTES    = 6,
    parameter int         DATA_W       = 46,
    parameter int         HDR_EN       = 1,
    parameter logic [7:0] HDR_BYTE     = DEFAULT_HDR_BYTE,
    parameter int         CHK_EN       = 1,
    parameter int         MSB_FIRST    = 1,
    parameter int         TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        byte_data,
    input  logic              byte_done,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              busy,
    output logic              chk_err,
    output logic              timeout_err,
    output logic              overrun_err
);

    localparam int               VEC_W       = 8 * NUM_BYTES;
    localparam int               CNT_W       = $clog2(NUM_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(NUM_BYTES - 1);
    localparam frame_state_t     START_STATE = (HDR_EN != 0) ? HUNT : PAYLOAD;

    frame_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       xor_acc;
    logic [VEC_W-1:0] payload;
    logic [VEC_W-1:0] payload_ins;
    logic [VEC_W-1:0] frame_vec;
    logic             byte_done_q;
    logic             byte_stb;
    logic             frame_done;
    logic             timer_expired;

    assign byte_stb = byte_done && !byte_done_q;

    // Without a header the first payload byte is not yet "inside" a frame.
    assign busy = (state == CHECK) ||
                  (state == PAYLOAD && ((HDR_EN != 0) || cnt != '0));

    always_comb begin
        payload_ins = payload;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (cnt == CNT_W'(i)) begin
                payload_ins[8*((MSB_FIRST != 0) ? (NUM_BYTES - 1 - i) : i) +: 8] = byte_data;
            end
        end
    end

    always_comb begin
        if (CHK_EN != 0) begin
            frame_done = byte_stb && (state == CHECK) && (byte_data == xor_acc);
            frame_vec  = payload;
        end else begin
            frame_done = byte_stb && (state == PAYLOAD) && (cnt == LAST_IDX);
            frame_vec  = payload_ins;
        end
    end

    uart_frame_timer #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (byte_stb || !busy),
        .enable  (busy),
        .expired (timer_expired)
    );

    // A byte strobe always takes priority over a coincident timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= START_STATE;
            cnt         <= '0;
            xor_acc     <= '0;
            payload     <= '0;
            byte_done_q <= 1'b1;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            byte_done_q <= byte_done;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;

            if (byte_stb) begin
                case (state)
                    HUNT: begin
                        if (byte_data == HDR_BYTE) begin
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        payload <= payload_ins;
                        xor_acc <= xor_acc ^ byte_data;
                        if (cnt == LAST_IDX) begin
                            cnt <= '0;
                            if (CHK_EN != 0) begin
                                state <= CHECK;
                            end else begin
                                state   <= START_STATE;
                                xor_acc <= '0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    CHECK: begin
                        if (!frame_done) begin
                            chk_err <= 1'b1;
                        end
                        state   <= START_STATE;
                        cnt     <= '0;
                        xor_acc <= '0;
                    end
                    default: begin
                        state <= START_STATE;
                    end
                endcase
            end else if (timer_expired) begin
                timeout_err <= 1'b1;
                state       <= START_STATE;
                cnt         <= '0;
                xor_acc     <= '0;
            end

            // Holding register: a completion can only land when the slot is free or being accepted.
            if (frame_done) begin
                if (!frame_valid || frame_ready) begin
                    frame_data  <= frame_vec[DATA_W-1:0];
                    frame_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: a table of complete byte sequences plus
// hand-written sequences for timeout, overrun, accept/complete overlap and reset.
module tb_uart_frame_rx;

    localparam int T_OUT = 300;

    typedef struct {
        string       name;
        int          n;
        logic [79:0] bytes;
        int          exp_acc;
        int          exp_chk;
        logic [45:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;

    logic [7:0]  byte_data;
    logic        byte_done;
    logic        frame_ready;
    logic [45:0] frame_data;
    logic        frame_valid;
    logic        busy;
    logic        chk_err;
    logic        timeout_err;
    logic        overrun_err;

    logic [7:0]  b_byte_data;
    logic        b_byte_done;
    logic        b_frame_ready;
    logic [23:0] b_frame_data;
    logic        b_frame_valid;
    logic        b_busy;
    logic        b_chk_err;
    logic        b_timeout_err;
    logic        b_overrun_err;

    int n_checks = 0;
    int n_fail   = 0;
    int chk_cnt  = 0;
    int to_cnt   = 0;
    int ovr_cnt  = 0;
    int b_to_cnt = 0;
    logic [45:0] acc_log[$];
    logic [23:0] b_acc_log[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    uart_frame_rx #(
        .TIMEOUT_CLKS (T_OUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_data   (byte_data),
        .byte_done   (byte_done),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy),
        .chk_err     (chk_err),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    uart_frame_rx #(
        .NUM_BYTES    (3),
        .DATA_W       (24),
        .HDR_EN       (0),
        .CHK_EN       (0),
        .MSB_FIRST    (0),
        .TIMEOUT_CLKS (T_OUT)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .byte_data   (b_byte_data),
        .byte_done   (b_byte_done),
        .frame_data  (b_frame_data),
        .frame_valid (b_frame_valid),
        .frame_ready (b_frame_ready),
        .busy        (b_busy),
        .chk_err     (b_chk_err),
        .timeout_err (b_timeout_err),
        .overrun_err (b_overrun_err)
    );

    // Outputs are sampled mid-cycle; every accepted frame is logged once.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid && frame_ready) acc_log.push_back(frame_data);
            if (chk_err)     chk_cnt++;
            if (timeout_err) to_cnt++;
            if (overrun_err) ovr_cnt++;
            if (b_frame_valid && b_frame_ready) b_acc_log.push_back(b_frame_data);
            if (b_timeout_err) b_to_cnt++;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [45:0] acc_at(input int idx);
        if (idx < acc_log.size()) return acc_log[idx];
        return 'x;
    endfunction

    function automatic logic [23:0] b_acc_at(input int idx);
        if (idx < b_acc_log.size()) return b_acc_log[idx];
        return 'x;
    endfunction

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_clk();
        byte_data = b;
        byte_done = 1'b1;
        wait_clk();
        byte_done = 1'b0;
        wait_clk();
    endtask

    task automatic b_send_byte(input logic [7:0] b);
        wait_clk();
        b_byte_data = b;
        b_byte_done = 1'b1;
        wait_clk();
        b_byte_done = 1'b0;
        wait_clk();
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < v.n; i++) send_byte(v.bytes[79-8*i -: 8]);
        repeat (3) wait_clk();
    endtask

    initial begin
        int base_acc, base_chk, base_to, base_ovr;
        logic [79:0] seq;

        vecs[0] = '{"basic",       8,  80'hA5_01_02_03_04_05_06_07_00_00, 1, 0, 46'h01_0203_0405_06};
        vecs[1] = '{"bad_chk",     8,  80'hA5_01_02_03_04_05_06_00_00_00, 0, 1, 46'h0};
        vecs[2] = '{"after_bad",   8,  80'hA5_01_02_03_04_05_06_07_00_00, 1, 0, 46'h01_0203_0405_06};
        vecs[3] = '{"noise_hunt",  10, 80'h12_34_A5_10_20_30_40_50_60_70, 1, 0, 46'h10_2030_4050_60};
        vecs[4] = '{"hdr_in_data", 8,  80'hA5_A5_FF_00_A5_11_22_CC_00_00, 1, 0, 46'h25_FF00_A511_22};
        vecs[5] = '{"ff_bad_chk",  8,  80'hA5_FF_FF_FF_FF_FF_FF_01_00_00, 0, 1, 46'h0};
        vecs[6] = '{"ff_good",     8,  80'hA5_FF_FF_FF_FF_FF_FF_00_00_00, 1, 0, 46'h3F_FFFF_FFFF_FF};

        $display("[TB] uart_frame_rx directed test start");

        // byte_done held high through reset must not produce a byte
        reset = 1'b1;
        byte_done = 1'b1;
        byte_data = 8'hA5;
        frame_ready = 1'b1;
        b_byte_done = 1'b1;
        b_byte_data = 8'h11;
        b_frame_ready = 1'b1;
        repeat (4) wait_clk();
        checkOutput("reset_valid",   frame_valid, 0);
        checkOutput("reset_data",    frame_data,  0);
        checkOutput("reset_busy",    busy,        0);
        checkOutput("reset_errs",    {chk_err, timeout_err, overrun_err}, 0);
        reset = 1'b0;
        repeat (3) wait_clk();
        checkOutput("held_done_busy",   busy,   0);
        checkOutput("held_done_b_busy", b_busy, 0);
        byte_done = 1'b0;
        b_byte_done = 1'b0;
        repeat (2) wait_clk();

        for (int v = 0; v < 7; v++) begin
            base_acc = acc_log.size();
            base_chk = chk_cnt;
            base_ovr = ovr_cnt;
            applyStimulus(vecs[v]);
            checkOutput({vecs[v].name, "_frames"}, acc_log.size() - base_acc, vecs[v].exp_acc);
            checkOutput({vecs[v].name, "_chkerr"}, chk_cnt - base_chk, vecs[v].exp_chk);
            checkOutput({vecs[v].name, "_overrun"}, ovr_cnt - base_ovr, 0);
            checkOutput({vecs[v].name, "_busy"}, busy, 0);
            if (vecs[v].exp_acc != 0)
                checkOutput({vecs[v].name, "_data"}, acc_at(base_acc), vecs[v].exp_data);
        end

        // inter-byte timeout after a partial frame
        base_to = to_cnt;
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        checkOutput("to_busy_mid", busy, 1);
        repeat (T_OUT - 20) wait_clk();
        checkOutput("to_not_early", to_cnt - base_to, 0);
        checkOutput("to_busy_before", busy, 1);
        for (int i = 0; i < 60 && to_cnt == base_to; i++) wait_clk();
        checkOutput("to_pulse", to_cnt - base_to, 1);
        checkOutput("to_busy_after", busy, 0);
        base_acc = acc_log.size();
        applyStimulus(vecs[0]);
        checkOutput("to_recover_data", acc_at(base_acc), vecs[0].exp_data);

        // overrun: second frame dropped while first is held
        frame_ready = 1'b0;
        base_acc = acc_log.size();
        base_ovr = ovr_cnt;
        applyStimulus(vecs[0]);
        checkOutput("ovr_first_valid", frame_valid, 1);
        applyStimulus(vecs[3]);
        checkOutput("ovr_pulse", ovr_cnt - base_ovr, 1);
        checkOutput("ovr_held_data", frame_data, vecs[0].exp_data);
        checkOutput("ovr_no_accept", acc_log.size() - base_acc, 0);
        frame_ready = 1'b1;
        repeat (3) wait_clk();
        checkOutput("ovr_accept_cnt", acc_log.size() - base_acc, 1);
        checkOutput("ovr_accept_data", acc_at(base_acc), vecs[0].exp_data);
        checkOutput("ovr_valid_clear", frame_valid, 0);

        // completion in the same clock as the held frame is accepted
        frame_ready = 1'b0;
        base_acc = acc_log.size();
        base_ovr = ovr_cnt;
        applyStimulus(vecs[0]);
        seq = vecs[4].bytes;
        for (int i = 0; i < 7; i++) send_byte(seq[79-8*i -: 8]);
        wait_clk();
        byte_data = 8'hCC;
        byte_done = 1'b1;
        frame_ready = 1'b1;
        wait_clk();
        byte_done = 1'b0;
        repeat (3) wait_clk();
        checkOutput("same_clk_accepts", acc_log.size() - base_acc, 2);
        checkOutput("same_clk_first", acc_at(base_acc), vecs[0].exp_data);
        checkOutput("same_clk_second", acc_at(base_acc + 1), vecs[4].exp_data);
        checkOutput("same_clk_no_ovr", ovr_cnt - base_ovr, 0);

        // headerless LSB-first 3-byte instance
        base_acc = b_acc_log.size();
        b_send_byte(8'h11);
        checkOutput("b_busy_mid", b_busy, 1);
        b_send_byte(8'h22);
        b_send_byte(8'h33);
        repeat (3) wait_clk();
        checkOutput("b_frame_cnt", b_acc_log.size() - base_acc, 1);
        checkOutput("b_frame_data", b_acc_at(base_acc), 24'h332211);
        base_to = b_to_cnt;
        b_send_byte(8'h11);
        for (int i = 0; i < T_OUT + 40 && b_to_cnt == base_to; i++) wait_clk();
        checkOutput("b_to_pulse", b_to_cnt - base_to, 1);
        checkOutput("b_to_busy", b_busy, 0);
        base_acc = b_acc_log.size();
        b_send_byte(8'h44);
        b_send_byte(8'h55);
        b_send_byte(8'h66);
        repeat (3) wait_clk();
        checkOutput("b_resync_data", b_acc_at(base_acc), 24'h665544);

        // reset in the middle of a frame with byte_done held high
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        checkOutput("rst_mid_busy", busy, 1);
        wait_clk();
        byte_data = 8'hA5;
        byte_done = 1'b1;
        reset = 1'b1;
        repeat (2) wait_clk();
        reset = 1'b0;
        repeat (2) wait_clk();
        checkOutput("rst_mid_busy_after", busy, 0);
        checkOutput("rst_mid_data", frame_data, 0);
        checkOutput("rst_mid_valid", frame_valid, 0);
        byte_done = 1'b0;
        wait_clk();
        base_acc = acc_log.size();
        applyStimulus(vecs[6]);
        checkOutput("rst_restart_cnt", acc_log.size() - base_acc, 1);
        checkOutput("rst_restart_data", acc_at(base_acc), vecs[6].exp_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
